// File: rtl/pkt_nibble_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pkt_nibble_detect                                          |
// | Description : Sliding-window header hunter for 4-bit command streams.    |
// |               Packs PAY_BYTES payload bytes after each header, with an   |
// |               inter-nibble idle timeout. Optional checksum byte check is |
// |               enabled by defining PKT_NIBBLE_DETECT_CHKSUM_EN.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pkt_nibble_detect #(
   parameter int unsigned HDR_LEN     = 4,
   parameter logic [31:0] HDR_PATTERN = 32'h0000_55D5,
   parameter int unsigned PAY_BYTES   = 2,
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] din,
   input  logic       din_vld,
   output logic [7:0] dout,
   output logic       dout_vld,
   output logic       sof,
   output logic       eof,
   output logic       err
);

   localparam int unsigned       WIN_W       = 4 * HDR_LEN;
   localparam logic [WIN_W-1:0]  C_PATTERN   = HDR_PATTERN[WIN_W-1:0];
   localparam logic [3:0]        C_HDR_LEN   = 4'(HDR_LEN);
   localparam logic [7:0]        C_LAST_BYTE = 8'(PAY_BYTES - 1);
   localparam logic [15:0]       C_TIMEOUT   = 16'(TIMEOUT_CYC);

`ifdef PKT_NIBBLE_DETECT_CHKSUM_EN
   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_CSUM    = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_PAYLOAD = 2'd1
   } state_t;
`endif

   state_t           state_q, state_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic [3:0]       fill_q, fill_d;
   logic             phase_q, phase_d;
   logic [7:0]       byte_q, byte_d;
   logic [15:0]      idle_q, idle_d;
   logic [7:0]       dout_q, dout_d;
   logic             dout_vld_q, dout_vld_d;
   logic             sof_q, sof_d;
   logic             eof_q, eof_d;
   logic             err_q, err_d;
`ifdef PKT_NIBBLE_DETECT_CHKSUM_EN
   logic [7:0]       sum_q, sum_d;
   logic [3:0]       csum_hi_q, csum_hi_d;
`endif

   logic [WIN_W-1:0] w_win_shift;
   logic [3:0]       w_fill_nxt;
   logic [15:0]      w_idle_inc;
   logic             w_timeout;
   logic [7:0]       w_byte;

   assign w_win_shift = WIN_W'({win_q, din});
   assign w_fill_nxt  = (fill_q == C_HDR_LEN) ? fill_q : fill_q + 4'd1;
   assign w_idle_inc  = (idle_q == 16'hFFFF) ? idle_q : idle_q + 16'd1;
   // A zero timeout value disables the abort entirely.
   assign w_timeout   = (C_TIMEOUT != 16'd0) && (w_idle_inc == C_TIMEOUT);
   assign w_byte      = {dout_q[3:0], din};

   // Next-state and registered-output logic for hunt / payload / checksum.
   always_comb begin
      state_d    = state_q;
      win_d      = win_q;
      fill_d     = fill_q;
      phase_d    = phase_q;
      byte_d     = byte_q;
      idle_d     = 16'd0;
      dout_d     = dout_q;
      dout_vld_d = 1'b0;
      sof_d      = 1'b0;
      eof_d      = 1'b0;
      err_d      = 1'b0;
`ifdef PKT_NIBBLE_DETECT_CHKSUM_EN
      sum_d      = sum_q;
      csum_hi_d  = csum_hi_q;
`endif
      case (state_q)
         ST_HUNT: begin
            if (din_vld) begin
               win_d  = w_win_shift;
               fill_d = w_fill_nxt;
               if ((w_fill_nxt == C_HDR_LEN) && (w_win_shift == C_PATTERN)) begin
                  sof_d   = 1'b1;
                  state_d = ST_PAYLOAD;
                  win_d   = '0;
                  fill_d  = 4'd0;
               end
            end
         end
         ST_PAYLOAD: begin
            if (din_vld) begin
               dout_d  = w_byte;
               phase_d = ~phase_q;
               if (phase_q) begin
                  dout_vld_d = 1'b1;
                  byte_d     = byte_q + 8'd1;
`ifdef PKT_NIBBLE_DETECT_CHKSUM_EN
                  sum_d      = sum_q + w_byte;
`endif
                  if (byte_q == C_LAST_BYTE) begin
                     byte_d  = 8'd0;
                     phase_d = 1'b0;
`ifdef PKT_NIBBLE_DETECT_CHKSUM_EN
                     state_d = ST_CSUM;
`else
                     eof_d   = 1'b1;
                     state_d = ST_HUNT;
`endif
                  end
               end
            end else if (w_timeout) begin
               err_d   = 1'b1;
               state_d = ST_HUNT;
               phase_d = 1'b0;
               byte_d  = 8'd0;
`ifdef PKT_NIBBLE_DETECT_CHKSUM_EN
               sum_d   = 8'd0;
`endif
            end else begin
               idle_d = w_idle_inc;
            end
         end
`ifdef PKT_NIBBLE_DETECT_CHKSUM_EN
         ST_CSUM: begin
            if (din_vld) begin
               phase_d = ~phase_q;
               if (!phase_q) begin
                  csum_hi_d = din;
               end else begin
                  if (sum_q == {csum_hi_q, din}) begin
                     eof_d = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
                  state_d = ST_HUNT;
                  phase_d = 1'b0;
                  sum_d   = 8'd0;
               end
            end else if (w_timeout) begin
               err_d   = 1'b1;
               state_d = ST_HUNT;
               phase_d = 1'b0;
               byte_d  = 8'd0;
               sum_d   = 8'd0;
            end else begin
               idle_d = w_idle_inc;
            end
         end
`endif
         default: begin
            state_d = ST_HUNT;
            phase_d = 1'b0;
            byte_d  = 8'd0;
         end
      endcase
   end

   // State, window, counters and outputs; reset returns everything to hunt.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_HUNT;
         win_q      <= '0;
         fill_q     <= 4'd0;
         phase_q    <= 1'b0;
         byte_q     <= 8'd0;
         idle_q     <= 16'd0;
         dout_q     <= 8'h00;
         dout_vld_q <= 1'b0;
         sof_q      <= 1'b0;
         eof_q      <= 1'b0;
         err_q      <= 1'b0;
`ifdef PKT_NIBBLE_DETECT_CHKSUM_EN
         sum_q      <= 8'd0;
         csum_hi_q  <= 4'd0;
`endif
      end else begin
         state_q    <= state_d;
         win_q      <= win_d;
         fill_q     <= fill_d;
         phase_q    <= phase_d;
         byte_q     <= byte_d;
         idle_q     <= idle_d;
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
         sof_q      <= sof_d;
         eof_q      <= eof_d;
         err_q      <= err_d;
`ifdef PKT_NIBBLE_DETECT_CHKSUM_EN
         sum_q      <= sum_d;
         csum_hi_q  <= csum_hi_d;
`endif
      end
   end

   assign dout     = dout_q;
   assign dout_vld = dout_vld_q;
   assign sof      = sof_q;
   assign eof      = eof_q;
   assign err      = err_q;

endmodule
`default_nettype wire
